// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory responder.
package mem_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int ADDR_W_DEF      = 8;
  localparam int STACK_BASE_DEF  = 255;
  localparam int STACK_LIMIT_DEF = 224;

  // LOAD: loader owns the array; RUN: core owns it; FAULT: frozen until reset.
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: N_RD combinational read ports, one synchronous write port.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int N_RD   = 5
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [ADDR_W-1:0]              i_waddr,
  input  logic [DATA_W-1:0]              i_wdata,
  input  logic [N_RD-1:0][ADDR_W-1:0]    i_raddr,
  output logic [N_RD-1:0][DATA_W-1:0]    o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Single write port; contents survive reset so a loaded program is kept.
  // NOTE: storage has no reset branch -- clearing it would need a DEPTH-cycle sweep or turn the RAM into flops.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Asynchronous reads: a same-cycle write only becomes visible after the edge.
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    assign o_rdata[k] = r_mem[i_raddr[k]];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: loader, fetch/operand/store ports, hardware stack and fault flags.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int STACK_BASE    = STACK_BASE_DEF,
  parameter int STACK_LIMIT   = STACK_LIMIT_DEF,
  parameter int LOAD_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem1RE,
  input  logic              mem2RE,
  input  logic              mem3RE,
  input  logic              mem4RE,
  input  logic              memWE,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] instr1,
  output logic [DATA_W-1:0] instr2,
  output logic [DATA_W-1:0] instr3,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] pop_data,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] sp,
  output logic              ovf,
  output logic              unf,
  output logic              err
);

  localparam logic [ADDR_W-1:0] SP_BASE  = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(STACK_LIMIT);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam state_t            ST_RST   = (LOAD_ON_RESET != 0) ? S_LOAD : S_RUN;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_sp, w_sp_nxt;
  logic [ADDR_W-1:0]   r_ld_addr, w_ld_addr_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic                r_unf, w_unf_nxt;
  logic                r_err, w_err_nxt;

  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [4:0][ADDR_W-1:0] w_raddr;
  logic [4:0][DATA_W-1:0] w_rd;
  logic [1:0]          w_n_strobes;
  logic                w_collide;

  // Read ports: 0..2 fetch window, 3 stack top (sp+1), 4 operand address.
  assign w_raddr[0] = pc;
  assign w_raddr[1] = pc + ONE;
  assign w_raddr[2] = pc + ADDR_W'(2);
  assign w_raddr[3] = r_sp + ONE;
  assign w_raddr[4] = addr;

  assign w_n_strobes = {1'b0, memWE} + {1'b0, push} + {1'b0, pop};
  assign w_collide   = (w_n_strobes >= 2'd2);

  // Writes are suppressed while reset is asserted so reset never disturbs contents.
  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(5)) u_array (
    .clk     (clk),
    .i_we    (w_we & rst),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rd)
  );

  // Next-state, write-port mux, SP and flag updates.
  // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
  always_comb begin
    w_state_nxt   = r_state;
    w_sp_nxt      = r_sp;
    w_ld_addr_nxt = r_ld_addr;
    w_rdata_nxt   = r_rdata;
    w_ovf_nxt     = r_ovf;
    w_unf_nxt     = r_unf;
    w_err_nxt     = r_err;
    w_we          = 1'b0;
    w_waddr       = addr;
    w_wdata       = wdata;
    unique case (r_state)
      S_LOAD: begin
        if (ld_valid) begin
          w_we          = 1'b1;
          w_waddr       = r_ld_addr;
          w_wdata       = ld_data;
          w_ld_addr_nxt = r_ld_addr + ONE;
          if (ld_last) begin
            w_state_nxt = S_RUN;
          end else if (r_ld_addr == '1) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_FAULT;
          end
        end
      end
      S_RUN: begin
        if (mem4RE) w_rdata_nxt = w_rd[4];
        if (w_collide) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_FAULT;
        end else if (push) begin
          if (r_sp == SP_LIMIT) begin
            w_ovf_nxt   = 1'b1;
            w_state_nxt = S_FAULT;
          end else begin
            w_we     = 1'b1;
            w_waddr  = r_sp;
            w_sp_nxt = r_sp - ONE;
          end
        end else if (pop) begin
          if (r_sp == SP_BASE) begin
            w_unf_nxt   = 1'b1;
            w_state_nxt = S_FAULT;
          end else begin
            w_sp_nxt = r_sp + ONE;
          end
        end else if (memWE) begin
          w_we = 1'b1;
        end
      end
      S_FAULT: ;
      default: w_state_nxt = S_FAULT;
    endcase
  end

  // State registers with synchronous active-low reset.
  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_RST;
      r_sp      <= SP_BASE;
      r_ld_addr <= '0;
      r_rdata   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sp      <= w_sp_nxt;
      r_ld_addr <= w_ld_addr_nxt;
      r_rdata   <= w_rdata_nxt;
      r_ovf     <= w_ovf_nxt;
      r_unf     <= w_unf_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign instr1   = mem1RE ? w_rd[0] : '0;
  assign instr2   = mem2RE ? w_rd[1] : '0;
  assign instr3   = mem3RE ? w_rd[2] : '0;
  assign pop_data = (pop && (r_sp != SP_BASE)) ? w_rd[3] : '0;
  assign rdata    = r_rdata;
  assign sp       = r_sp;
  assign ovf      = r_ovf;
  assign unf      = r_unf;
  assign err      = r_err;
  assign busy     = (r_state != S_RUN);
  assign ld_ready = (r_state == S_LOAD);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: fetch vector table, hand-written corner sequences and
// randomized traffic, all checked against a behavioural model of the responder.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int BASE  = 255;
  localparam int LIMIT = 224;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem1RE, mem2RE, mem3RE, mem4RE, memWE, push, pop;
  logic [7:0] pc, addr, wdata, ld_data;
  logic       ld_valid, ld_last;
  logic [7:0] instr1, instr2, instr3, rdata, pop_data, sp;
  logic       ld_ready, busy, ovf, unf, err;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .rst(rst),
    .mem1RE(mem1RE), .mem2RE(mem2RE), .mem3RE(mem3RE), .mem4RE(mem4RE),
    .memWE(memWE), .push(push), .pop(pop),
    .pc(pc), .addr(addr), .wdata(wdata),
    .instr1(instr1), .instr2(instr2), .instr3(instr3),
    .rdata(rdata), .pop_data(pop_data),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .busy(busy), .sp(sp), .ovf(ovf), .unf(unf), .err(err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [DEPTH];
  int         m_mode;     // 0 loading, 1 running, 2 faulted
  int         m_sp, m_ld_addr;
  logic [7:0] m_rdata;
  bit         m_ovf, m_unf, m_err;

  task automatic model_reset();
    m_mode = 0; m_sp = BASE; m_ld_addr = 0; m_rdata = 8'h00;
    m_ovf = 0; m_unf = 0; m_err = 0;
  endtask

  function automatic logic [7:0] exp_fetch(input int k, input logic re);
    if (re !== 1'b1) return 8'h00;
    return m_mem[(int'(pc) + k - 1) % DEPTH];
  endfunction

  function automatic logic [7:0] exp_pop();
    if (pop !== 1'b1 || m_sp == BASE) return 8'h00;
    return m_mem[(m_sp + 1) % DEPTH];
  endfunction

  // Apply one clock edge worth of rules to the model, using the current inputs.
  task automatic model_clock();
    int n;
    if (!rst) begin model_reset(); return; end
    if (m_mode == 0) begin
      if (ld_valid) begin
        m_mem[m_ld_addr] = ld_data;
        if (ld_last) m_mode = 1;
        else if (m_ld_addr == DEPTH - 1) begin m_err = 1; m_mode = 2; end
        m_ld_addr = (m_ld_addr + 1) % DEPTH;
      end
    end else if (m_mode == 1) begin
      n = int'(memWE) + int'(push) + int'(pop);
      if (mem4RE) m_rdata = m_mem[addr];
      if (n >= 2) begin m_err = 1; m_mode = 2; end
      else if (push) begin
        if (m_sp == LIMIT) begin m_ovf = 1; m_mode = 2; end
        else begin m_mem[m_sp] = wdata; m_sp = m_sp - 1; end
      end else if (pop) begin
        if (m_sp == BASE) begin m_unf = 1; m_mode = 2; end
        else m_sp = m_sp + 1;
      end else if (memWE) m_mem[addr] = wdata;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    {mem1RE, mem2RE, mem3RE, mem4RE, memWE, push, pop} = '0;
    {ld_valid, ld_last} = '0;
    pc = 8'h00; addr = 8'h00; wdata = 8'h00; ld_data = 8'h00;
  endtask

  // Called at posedge+1 with inputs set: checks combinational outputs, advances one edge,
  // then checks registered outputs against the model.
  task automatic cycle(input string tag);
    #1;
    check({tag, " instr1"},   instr1,   exp_fetch(1, mem1RE));
    check({tag, " instr2"},   instr2,   exp_fetch(2, mem2RE));
    check({tag, " instr3"},   instr3,   exp_fetch(3, mem3RE));
    check({tag, " pop_data"}, pop_data, exp_pop());
    check({tag, " ld_ready"}, ld_ready, m_mode == 0);
    model_clock();
    @(posedge clk); #1;
    check({tag, " sp"},    sp,    m_sp[7:0]);
    check({tag, " rdata"}, rdata, m_rdata);
    check({tag, " busy"},  busy,  m_mode != 1);
    check({tag, " ovf"},   ovf,   m_ovf);
    check({tag, " unf"},   unf,   m_unf);
    check({tag, " err"},   err,   m_err);
  endtask

  task automatic reset_dut(input int n);
    idle();
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    check("reset busy", busy, 1);
    check("reset ld_ready", ld_ready, 1);
    check("reset sp", sp, 8'hFF);
    check("reset rdata", rdata, 8'h00);
    check("reset flags", {ovf, unf, err}, 3'b000);
  endtask

  task automatic load_word(input logic [7:0] d, input logic last, input string tag);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    cycle(tag);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string tag);
    pc = a; mem1RE = 1'b1;
    #1 check(tag, instr1, exp);
    mem1RE = 1'b0;
  endtask

  typedef struct {
    logic [7:0] pc;
    logic [2:0] re;
    logic [7:0] e1, e2, e3;
  } fvec_t;

  fvec_t      tbl [4];
  logic [7:0] saved_a, saved_b;
  int         op;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    reset_dut(2);

    // Fill every location so later fetch and stack reads have known contents.
    for (int i = 0; i < DEPTH; i++) load_word(8'($urandom), i == DEPTH - 1, "full_load");
    check("full_load run", busy, 0);

    // Plan load: three words, last on the third.
    reset_dut(2);
    load_word(8'h11, 1'b0, "load0");
    load_word(8'h22, 1'b0, "load1");
    load_word(8'h33, 1'b1, "load2");
    check("load busy drop", busy, 0);

    // Fetch table, including pc wrap at the top of memory.
    tbl[0] = '{8'd1,   3'b111, 8'h22,       8'h33, m_mem[3]};
    tbl[1] = '{8'd255, 3'b111, m_mem[255],  8'h11, 8'h22};
    tbl[2] = '{8'd254, 3'b101, m_mem[254],  8'h00, 8'h11};
    tbl[3] = '{8'd0,   3'b000, 8'h00,       8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      pc = tbl[i].pc;
      {mem3RE, mem2RE, mem1RE} = tbl[i].re;
      #1;
      check($sformatf("fetch[%0d] instr1", i), instr1, tbl[i].e1);
      check($sformatf("fetch[%0d] instr2", i), instr2, tbl[i].e2);
      check($sformatf("fetch[%0d] instr3", i), instr3, tbl[i].e3);
      cycle("fetch");
    end
    idle();

    // Read-before-write on the same address; fetch sees the old word this cycle.
    addr = 8'd2; mem4RE = 1'b1; memWE = 1'b1; wdata = 8'h5A; pc = 8'd2; mem1RE = 1'b1;
    #1 check("rbw fetch old", instr1, 8'h33);
    cycle("rbw");
    check("rbw rdata old", rdata, 8'h33);
    idle(); addr = 8'd2; mem4RE = 1'b1;
    cycle("reread");
    check("reread rdata new", rdata, 8'h5A);
    idle();

    // Push/pop round trip.
    push = 1'b1; wdata = 8'hA1; cycle("push1"); check("push1 sp", sp, 8'd254);
    wdata = 8'hA2;              cycle("push2"); check("push2 sp", sp, 8'd253);
    push = 1'b0; pop = 1'b1;
    #1 check("pop1 data", pop_data, 8'hA2);
    cycle("pop1"); check("pop1 sp", sp, 8'd254);
    #1 check("pop2 data", pop_data, 8'hA1);
    cycle("pop2"); check("pop2 sp", sp, 8'd255);
    idle();
    check("pushpop flags", {ovf, unf, err}, 3'b000);

    // Randomized legal traffic (no fault-producing combinations).
    for (int i = 0; i < 400; i++) begin
      idle();
      pc = 8'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      {mem3RE, mem2RE, mem1RE} = 3'($urandom);
      op = $urandom_range(0, 6);
      case (op)
        1: memWE = 1'b1;
        2: mem4RE = 1'b1;
        3: begin memWE = 1'b1; mem4RE = 1'b1; end
        4, 6: push = (m_sp != LIMIT);
        5: pop = (m_sp != BASE);
        default: ;
      endcase
      cycle("rand");
    end
    idle();

    // Overflow: 31 pushes to the limit, the 32nd faults without writing.
    reset_dut(1);
    load_word(8'h5C, 1'b1, "ovf_load");
    push = 1'b1;
    for (int i = 0; i < 31; i++) begin wdata = 8'(i + 8'h40); cycle("fill"); end
    check("fill sp", sp, 8'd224);
    saved_a = m_mem[224];
    wdata = ~saved_a;
    cycle("ovf_push");
    check("ovf flag", ovf, 1);
    check("ovf busy", busy, 1);
    check("ovf sp", sp, 8'd224);
    idle();
    peek(8'd224, saved_a, "ovf mem224");
    saved_b = m_mem[5];
    memWE = 1'b1; mem4RE = 1'b1; addr = 8'd5; wdata = ~saved_b;
    cycle("fault store");
    memWE = 1'b0; mem4RE = 1'b0; push = 1'b1;
    cycle("fault push");
    idle();
    check("fault sp", sp, 8'd224);
    check("fault rdata", rdata, 8'h00);
    peek(8'd5, saved_b, "fault mem5");

    // Underflow from an empty stack.
    reset_dut(1);
    load_word(8'h01, 1'b1, "unf_load");
    pop = 1'b1;
    #1 check("unf pop_data", pop_data, 8'h00);
    cycle("unf_pop");
    idle();
    check("unf flag", unf, 1);
    check("unf busy", busy, 1);
    check("unf sp", sp, 8'hFF);

    // Reset in the middle of a load restarts the loader at address 0.
    reset_dut(1);
    load_word(8'h77, 1'b0, "mid_load");
    reset_dut(1);
    peek(8'd0, 8'h77, "mid mem0 kept");
    saved_a = m_mem[1];
    load_word(8'h99, 1'b1, "reload");
    peek(8'd0, 8'h99, "reload mem0");
    peek(8'd1, saved_a, "reload mem1");

    // Push and store together: error, nothing written, SP unchanged.
    saved_a = m_mem[255]; saved_b = m_mem[10];
    push = 1'b1; memWE = 1'b1; addr = 8'd10; wdata = 8'hEE;
    cycle("collide");
    idle();
    check("collide err", err, 1);
    check("collide sp", sp, 8'hFF);
    peek(8'd255, saved_a, "collide mem255");
    peek(8'd10,  saved_b, "collide mem10");

    // Loader running off the end of memory without ld_last.
    reset_dut(1);
    for (int i = 0; i < DEPTH; i++) load_word(8'(i) ^ 8'h3C, 1'b0, "ld_over");
    check("ld_over err", err, 1);
    check("ld_over busy", busy, 1);
    check("ld_over ld_ready", ld_ready, 0);
    peek(8'd255, 8'hC3, "ld_over mem255");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
